// File: rtl/psum_bank_resp.sv
// PSUM bank responder: accumulates NUM_CONTRIB saturating MAC partial sums,
// then hands the finished sum downstream and reports idleness to the arbiter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   PEBPSUM_Flush     abort current PSUM, return to IDLE
//   ARBPSUM_fnh       arbiter flag: 0 = bank open, 1 = no more assignment
//   PSUMARB_empty     bank idle and free
//   MACPSUM_Val/Dat/Rdy  incoming partial sums (valid/ready)
//   PSUMGB_Val/Dat/Rdy   finished sum downstream (valid/ready)
//   PSUMGB_Sat        finished sum saturated at least once
//   PSUMPEB_Cnt       contributions accepted so far
module psum_bank_resp #(
  parameter int PSUM_WIDTH  = 24,
  parameter int NUM_CONTRIB = 9,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PEBPSUM_Flush,
  input  logic                  ARBPSUM_fnh,
  output logic                  PSUMARB_empty,
  input  logic                  MACPSUM_Val,
  input  logic [PSUM_WIDTH-1:0] MACPSUM_Dat,
  output logic                  MACPSUM_Rdy,
  output logic                  PSUMGB_Val,
  output logic [PSUM_WIDTH-1:0] PSUMGB_Dat,
  input  logic                  PSUMGB_Rdy,
  output logic                  PSUMGB_Sat,
  output logic [CNT_WIDTH-1:0]  PSUMPEB_Cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [PSUM_WIDTH-1:0] MAXV =
    {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] MINV =
    {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(NUM_CONTRIB - 1);

  state_t                state_q;
  logic [PSUM_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  sat_q;
  logic                  empty_q;
  logic                  mrdy_q;
  logic                  val_q;

  logic [PSUM_WIDTH:0]   sum_d;
  logic                  clamp_d;
  logic [PSUM_WIDTH-1:0] acc_d;
  logic                  last_d;

  // One extra bit of headroom; overflow shows as a mismatch
  // between the two top bits, the top bit giving the direction.
  assign sum_d = {acc_q[PSUM_WIDTH-1], acc_q}
               + {MACPSUM_Dat[PSUM_WIDTH-1], MACPSUM_Dat};
  assign clamp_d = sum_d[PSUM_WIDTH] ^ sum_d[PSUM_WIDTH-1];
  assign acc_d = clamp_d
               ? (sum_d[PSUM_WIDTH] ? MINV : MAXV)
               : sum_d[PSUM_WIDTH-1:0];
  assign last_d = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst || PEBPSUM_Flush) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      empty_q <= 1'b1;
      mrdy_q  <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!ARBPSUM_fnh) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            empty_q <= 1'b0;
            mrdy_q  <= 1'b1;
          end
        end
        ACC: begin
          if (MACPSUM_Val && mrdy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            sat_q <= sat_q | clamp_d;
            if (last_d) begin
              state_q <= OUT;
              mrdy_q  <= 1'b0;
              val_q   <= 1'b1;
            end
          end
        end
        OUT: begin
          if (PSUMGB_Rdy) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            empty_q <= 1'b1;
            val_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          acc_q   <= '0;
          cnt_q   <= '0;
          sat_q   <= 1'b0;
          empty_q <= 1'b1;
          mrdy_q  <= 1'b0;
          val_q   <= 1'b0;
        end
      endcase
    end
  end

  assign PSUMARB_empty = empty_q;
  assign MACPSUM_Rdy   = mrdy_q;
  assign PSUMGB_Val    = val_q;
  assign PSUMGB_Dat    = acc_q;
  assign PSUMGB_Sat    = sat_q;
  assign PSUMPEB_Cnt   = cnt_q;

endmodule

// File: tb/tb_psum_bank_resp.sv
// Testbench for psum_bank_resp: directed scenarios plus random traffic
// checked against a cycle model built from plain integer arithmetic.
module tb_psum_bank_resp;

  localparam int W   = 24;
  localparam int N   = 9;
  localparam int CW  = 4;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          fnh;
  logic          empty;
  logic          mval;
  logic [W-1:0]  mdat;
  logic          mrdy;
  logic          gval;
  logic [W-1:0]  gdat;
  logic          grdy;
  logic          gsat;
  logic [CW-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  psum_bank_resp #(
    .PSUM_WIDTH(W), .NUM_CONTRIB(N), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .PEBPSUM_Flush(flush),
    .ARBPSUM_fnh(fnh), .PSUMARB_empty(empty),
    .MACPSUM_Val(mval), .MACPSUM_Dat(mdat), .MACPSUM_Rdy(mrdy),
    .PSUMGB_Val(gval), .PSUMGB_Dat(gdat), .PSUMGB_Rdy(grdy),
    .PSUMGB_Sat(gsat), .PSUMPEB_Cnt(cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 free, 1 collecting, 2 holding result.
  int     m_ph  = 0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_sat = 0;

  always @(posedge clk) begin
    longint s;
    if (rst || flush) begin
      m_ph = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
    end else if (m_ph == 0) begin
      if (!fnh) begin
        m_ph = 1; m_acc = 0; m_cnt = 0; m_sat = 0;
      end
    end else if (m_ph == 1) begin
      if (mval) begin
        s = m_acc + longint'($signed(mdat));
        if (s > MAXV) begin s = MAXV; m_sat = 1; end
        if (s < MINV) begin s = MINV; m_sat = 1; end
        m_acc = s;
        m_cnt = m_cnt + 1;
        if (m_cnt == N) m_ph = 2;
      end
    end else begin
      if (grdy) begin
        m_ph = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
      end
    end
  end

  function automatic logic [31:0] exp_vec();
    logic [W-1:0] a;
    a = W'(m_acc);
    return {m_ph == 0, m_ph == 1, m_ph == 2, a, m_sat, CW'(m_cnt)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {empty, mrdy, gval, gdat, gsat, cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; fnh = 1; mval = 0; mdat = '0; grdy = 0;
  endtask

  task automatic open_bank();
    fnh = 0;
    tick();
    fnh = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    tick(); tick();
    n_cmp++;
    if (dut_vec() !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", dut_vec(), 32'h8000_0000);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    open_bank();
    n_cmp++;
    if (empty !== 1'b0 || mrdy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_open: empty %b rdy %b want 0 1", empty, mrdy);
    end
    for (int i = 0; i < N; i++) begin
      mval = 1; mdat = 24'd10;
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL basic_acc: got %h want %h", dut_vec(), exp_vec());
      end
    end
    mval = 0;
    n_cmp++;
    if (gval !== 1'b1 || gdat !== 24'd90 || gsat !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_out: val %b dat %0d sat %b want 1 90 0",
               gval, gdat, gsat);
    end
    grdy = 1;
    tick();
    grdy = 0;
    n_cmp++;
    if (empty !== 1'b1 || gval !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: empty %b val %b want 1 0", empty, gval);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    open_bank();
    for (int i = 0; i < N; i++) begin
      mval = 1; mdat = W'($urandom_range(0, 2000)) - W'(1000);
      tick();
    end
    mval = 1;
    held = W'(m_acc);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (gval !== 1'b1 || gdat !== held || mrdy !== 1'b0 ||
          empty !== 1'b0 || cnt !== 4'd9) begin
        n_bad++;
        $display("FAIL bp_hold: val %b dat %h rdy %b empty %b want 1 %h 0 0",
                 gval, gdat, mrdy, empty, held);
      end
    end
    mval = 0; grdy = 1;
    tick();
    grdy = 0;
    n_cmp++;
    if (empty !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL bp_release: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] vals [2];
    logic [W-1:0] want [2];
    vals[0] = 24'h3FFFFF; want[0] = 24'h7FFFFF;
    vals[1] = 24'hC00000; want[1] = 24'h800000;
    for (int k = 0; k < 2; k++) begin
      open_bank();
      for (int i = 0; i < N; i++) begin
        mval = 1; mdat = vals[k];
        tick();
      end
      mval = 0;
      n_cmp++;
      if (gval !== 1'b1 || gdat !== want[k] || gsat !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_%0d: val %b dat %h sat %b want 1 %h 1",
                 k, gval, gdat, gsat, want[k]);
      end
      grdy = 1;
      tick();
      grdy = 0;
      n_cmp++;
      if (gsat !== 1'b0 || empty !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_clear_%0d: sat %b empty %b want 0 1",
                 k, gsat, empty);
      end
    end
  endtask

  task automatic test_gaps();
    int budget;
    int seen;
    fnh = 0;
    tick();
    seen = 0;
    budget = 60;
    while (m_ph != 2 && budget > 0) begin
      mval = ($urandom_range(0, 1) == 1);
      mdat = W'($urandom_range(0, 500));
      if (seen >= 4) fnh = 1;
      tick();
      budget--;
      seen = m_cnt;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gaps_step: got %h want %h", dut_vec(), exp_vec());
      end
    end
    mval = 0; fnh = 1;
    n_cmp++;
    if (budget == 0 || gval !== 1'b1 || cnt !== 4'd9) begin
      n_bad++;
      $display("FAIL gaps_done: val %b cnt %0d want 1 9", gval, cnt);
    end
    grdy = 1;
    tick();
    grdy = 0;
  endtask

  task automatic test_flush();
    open_bank();
    for (int i = 0; i < 5; i++) begin
      mval = 1; mdat = 24'd7;
      tick();
    end
    flush = 1; mval = 1; mdat = 24'd7;
    tick();
    flush = 0; mval = 0;
    n_cmp++;
    if (empty !== 1'b1 || cnt !== 4'd0 || gdat !== 24'd0) begin
      n_bad++;
      $display("FAIL flush: empty %b cnt %0d dat %0d want 1 0 0",
               empty, cnt, gdat);
    end
    open_bank();
    for (int i = 0; i < N; i++) begin
      mval = 1; mdat = 24'd3;
      tick();
    end
    mval = 0;
    n_cmp++;
    if (gval !== 1'b1 || gdat !== 24'd27) begin
      n_bad++;
      $display("FAIL flush_restart: val %b dat %0d want 1 27", gval, gdat);
    end
    grdy = 1;
    tick();
    grdy = 0;
  endtask

  task automatic test_reset_out();
    open_bank();
    for (int i = 0; i < N; i++) begin
      mval = 1; mdat = 24'd100;
      tick();
    end
    mval = 0;
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if (dut_vec() !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL reset_out: got %h want %h", dut_vec(), 32'h8000_0000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fnh   = ($urandom_range(0, 3) == 0);
      mval  = ($urandom_range(0, 3) != 0);
      mdat  = W'($urandom);
      grdy  = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 40) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_gaps();
    test_flush();
    test_reset_out();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
